// File: rtl/ip_pkg.sv
// Shared IPv4 definitions: header byte offsets, error/state encodings and the
// ones-complement add used by both the RX checker and the TX checksum generator.
package ip_pkg;

  localparam logic [3:0]  IP_VER      = 4'd4;
  localparam logic [3:0]  IHL_MIN     = 4'd5;

  localparam logic [15:0] OFF_TOT_LEN = 16'd2;
  localparam logic [15:0] OFF_ID      = 16'd4;
  localparam logic [15:0] OFF_FRAG    = 16'd6;
  localparam logic [15:0] OFF_TTL     = 16'd8;
  localparam logic [15:0] OFF_PROTO   = 16'd9;
  localparam logic [15:0] OFF_CSUM    = 16'd10;
  localparam logic [15:0] OFF_SRC_IP  = 16'd12;
  localparam logic [15:0] OFF_DST_IP  = 16'd16;

  typedef enum logic [2:0] {
    ERR_OK     = 3'd0,
    ERR_VER    = 3'd1,
    ERR_IHL    = 3'd2,
    ERR_CSUM   = 3'd3,
    ERR_SHORT  = 3'd4,
    ERR_TOTLEN = 3'd5,
    ERR_DST    = 3'd6
  } err_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PAY  = 2'd2,
    ST_DROP = 2'd3
  } state_e;

  // End-around carry folded once; a single fold can never overflow 16 bits.
  function automatic logic [15:0] oc_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

endpackage

// File: rtl/ip_hdr_rx_check_if.sv
// Byte stream into the header checker and payload stream out towards UDP.
interface ip_hdr_rx_check_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_sop;
  logic       in_eop;
  logic [7:0] pay_data;
  logic       pay_valid;
  logic       pay_last;

  modport master (
    output in_data, in_valid, in_sop, in_eop,
    input  pay_data, pay_valid, pay_last
  );

  modport slave (
    input  in_data, in_valid, in_sop, in_eop,
    output pay_data, pay_valid, pay_last
  );
endinterface

// File: rtl/ip_hdr_rx_check_ones_comp_acc.sv
// 16-bit ones-complement accumulator. sum reflects this cycle's clear/add so a
// verdict can be formed in the same cycle as the final header word.
module ones_comp_acc
  import ip_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        add,
  input  logic [15:0] word,
  output logic [15:0] sum
);

  logic [15:0] sum_q;
  logic [15:0] sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr) begin
      sum_d = 16'h0000;
    end else if (add) begin
      sum_d = oc_add16(sum_q, word);
    end else begin
      sum_d = sum_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= 16'h0000;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_d;

endmodule

// File: rtl/ip_hdr_rx_check.sv
// IPv4 RX header parser and checksum verifier; forwards payload trimmed to tot_len.
// Build option IP_DST_FILTER_EN drops datagrams whose dst_ip differs from LOCAL_IP.
module ip_hdr_rx_check
  import ip_pkg::*;
#(
  parameter logic [31:0] LOCAL_IP = 32'hc0a80002
) (
  input  logic             clk,
  input  logic             rst,
  ip_hdr_rx_check_if.slave rx,
  output logic             hdr_done,
  output logic             hdr_ok,
  output logic [2:0]       err_code,
  output logic [3:0]       ver,
  output logic [3:0]       hdr_len,
  output logic [15:0]      tot_len,
  output logic [15:0]      id,
  output logic [15:0]      offset,
  output logic [15:0]      rx_check_sum,
  output logic [7:0]       ttl,
  output logic [7:0]       protocol,
  output logic [31:0]      src_ip,
  output logic [31:0]      dst_ip
);

  state_e      state_q,    state_d;
  logic [15:0] cnt_q,      cnt_d;
  logic [7:0]  hi_q,       hi_d;
  logic [3:0]  ver_q,      ver_d;
  logic [3:0]  hdr_len_q,  hdr_len_d;
  logic [15:0] tot_len_q,  tot_len_d;
  logic [15:0] id_q,       id_d;
  logic [15:0] offset_q,   offset_d;
  logic [15:0] csum_q,     csum_d;
  logic [7:0]  ttl_q,      ttl_d;
  logic [7:0]  proto_q,    proto_d;
  logic [31:0] src_ip_q,   src_ip_d;
  logic [31:0] dst_ip_q,   dst_ip_d;
  logic        hdr_done_q, hdr_done_d;
  logic        hdr_ok_q,   hdr_ok_d;
  err_e        err_q,      err_d;
  logic [7:0]  pay_data_q, pay_data_d;
  logic        pay_valid_q, pay_valid_d;
  logic        pay_last_q, pay_last_d;

  logic        acc_clr_s;
  logic        acc_add_s;
  logic [15:0] acc_sum_s;
  logic [15:0] hdr_bytes_s;
  logic        last_hdr_s;
  logic        dst_bad_s;
  err_e        verdict_s;

  ones_comp_acc u_acc (
    .clk  (clk),
    .rst  (rst),
    .clr  (acc_clr_s),
    .add  (acc_add_s),
    .word ({hi_q, rx.in_data}),
    .sum  (acc_sum_s)
  );

  assign hdr_bytes_s = {10'd0, hdr_len_q, 2'b00};
  assign last_hdr_s  = (cnt_q == (hdr_bytes_s - 16'd1));

`ifdef IP_DST_FILTER_EN
  logic [31:0] dst_now_s;
  // With a 20-byte header the last dst byte is still on the bus at verdict time.
  assign dst_now_s = (cnt_q == (OFF_DST_IP + 16'd3)) ? {dst_ip_q[23:0], rx.in_data} : dst_ip_q;
  assign dst_bad_s = (dst_now_s != LOCAL_IP);
`else
  logic unused_local_ip_s;
  assign unused_local_ip_s = ^LOCAL_IP;
  assign dst_bad_s         = 1'b0;
`endif

  always_comb begin
    verdict_s = ERR_OK;
    if (tot_len_q < hdr_bytes_s) begin
      verdict_s = ERR_TOTLEN;
    end else if (acc_sum_s != 16'hFFFF) begin
      verdict_s = ERR_CSUM;
    end else if (dst_bad_s) begin
      verdict_s = ERR_DST;
    end else begin
      verdict_s = ERR_OK;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    ver_d       = ver_q;
    hdr_len_d   = hdr_len_q;
    tot_len_d   = tot_len_q;
    id_d        = id_q;
    offset_d    = offset_q;
    csum_d      = csum_q;
    ttl_d       = ttl_q;
    proto_d     = proto_q;
    src_ip_d    = src_ip_q;
    dst_ip_d    = dst_ip_q;
    hdr_done_d  = 1'b0;
    hdr_ok_d    = hdr_ok_q;
    err_d       = err_q;
    pay_data_d  = pay_data_q;
    pay_valid_d = 1'b0;
    pay_last_d  = 1'b0;
    acc_clr_s   = 1'b0;
    acc_add_s   = 1'b0;

    // A start-of-datagram byte restarts parsing from any state.
    if (rx.in_valid && rx.in_sop) begin
      cnt_d     = 16'd1;
      hi_d      = rx.in_data;
      ver_d     = rx.in_data[7:4];
      hdr_len_d = rx.in_data[3:0];
      acc_clr_s = 1'b1;
      hdr_ok_d  = 1'b0;
      err_d     = ERR_OK;
      if (rx.in_data[7:4] != IP_VER) begin
        hdr_done_d = 1'b1;
        err_d      = ERR_VER;
        state_d    = rx.in_eop ? ST_IDLE : ST_DROP;
      end else if (rx.in_data[3:0] < IHL_MIN) begin
        hdr_done_d = 1'b1;
        err_d      = ERR_IHL;
        state_d    = rx.in_eop ? ST_IDLE : ST_DROP;
      end else if (rx.in_eop) begin
        hdr_done_d = 1'b1;
        err_d      = ERR_SHORT;
        state_d    = ST_IDLE;
      end else begin
        state_d = ST_HDR;
      end
    end else if (rx.in_valid) begin
      case (state_q)
        ST_HDR: begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_q[0]) begin
            acc_add_s = 1'b1;
          end else begin
            hi_d = rx.in_data;
          end
          case (cnt_q)
            OFF_TOT_LEN:                   tot_len_d[15:8] = rx.in_data;
            OFF_TOT_LEN + 16'd1:           tot_len_d[7:0]  = rx.in_data;
            OFF_ID:                        id_d[15:8]      = rx.in_data;
            OFF_ID + 16'd1:                id_d[7:0]       = rx.in_data;
            OFF_FRAG:                      offset_d[15:8]  = rx.in_data;
            OFF_FRAG + 16'd1:              offset_d[7:0]   = rx.in_data;
            OFF_TTL:                       ttl_d           = rx.in_data;
            OFF_PROTO:                     proto_d         = rx.in_data;
            OFF_CSUM:                      csum_d[15:8]    = rx.in_data;
            OFF_CSUM + 16'd1:              csum_d[7:0]     = rx.in_data;
            OFF_SRC_IP, OFF_SRC_IP + 16'd1,
            OFF_SRC_IP + 16'd2, OFF_SRC_IP + 16'd3:
                                           src_ip_d = {src_ip_q[23:0], rx.in_data};
            OFF_DST_IP, OFF_DST_IP + 16'd1,
            OFF_DST_IP + 16'd2, OFF_DST_IP + 16'd3:
                                           dst_ip_d = {dst_ip_q[23:0], rx.in_data};
            default: begin
            end
          endcase
          if (last_hdr_s) begin
            hdr_done_d = 1'b1;
            err_d      = verdict_s;
            hdr_ok_d   = (verdict_s == ERR_OK);
            if (verdict_s != ERR_OK) begin
              state_d = rx.in_eop ? ST_IDLE : ST_DROP;
            end else if (rx.in_eop || (tot_len_q == hdr_bytes_s)) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_PAY;
            end
          end else if (rx.in_eop) begin
            hdr_done_d = 1'b1;
            err_d      = ERR_SHORT;
            state_d    = ST_IDLE;
          end else begin
            state_d = ST_HDR;
          end
        end
        ST_PAY: begin
          cnt_d       = cnt_q + 16'd1;
          pay_valid_d = 1'b1;
          pay_data_d  = rx.in_data;
          if (rx.in_eop || (cnt_q == (tot_len_q - 16'd1))) begin
            pay_last_d = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            state_d = ST_PAY;
          end
        end
        ST_DROP: begin
          state_d = rx.in_eop ? ST_IDLE : ST_DROP;
        end
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 16'd0;
      hi_q        <= 8'd0;
      ver_q       <= 4'd0;
      hdr_len_q   <= 4'd0;
      tot_len_q   <= 16'd0;
      id_q        <= 16'd0;
      offset_q    <= 16'd0;
      csum_q      <= 16'd0;
      ttl_q       <= 8'd0;
      proto_q     <= 8'd0;
      src_ip_q    <= 32'd0;
      dst_ip_q    <= 32'd0;
      hdr_done_q  <= 1'b0;
      hdr_ok_q    <= 1'b0;
      err_q       <= ERR_OK;
      pay_data_q  <= 8'd0;
      pay_valid_q <= 1'b0;
      pay_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      ver_q       <= ver_d;
      hdr_len_q   <= hdr_len_d;
      tot_len_q   <= tot_len_d;
      id_q        <= id_d;
      offset_q    <= offset_d;
      csum_q      <= csum_d;
      ttl_q       <= ttl_d;
      proto_q     <= proto_d;
      src_ip_q    <= src_ip_d;
      dst_ip_q    <= dst_ip_d;
      hdr_done_q  <= hdr_done_d;
      hdr_ok_q    <= hdr_ok_d;
      err_q       <= err_d;
      pay_data_q  <= pay_data_d;
      pay_valid_q <= pay_valid_d;
      pay_last_q  <= pay_last_d;
    end
  end

  assign hdr_done     = hdr_done_q;
  assign hdr_ok       = hdr_ok_q;
  assign err_code     = err_q;
  assign ver          = ver_q;
  assign hdr_len      = hdr_len_q;
  assign tot_len      = tot_len_q;
  assign id           = id_q;
  assign offset       = offset_q;
  assign rx_check_sum = csum_q;
  assign ttl          = ttl_q;
  assign protocol     = proto_q;
  assign src_ip       = src_ip_q;
  assign dst_ip       = dst_ip_q;
  assign rx.pay_data  = pay_data_q;
  assign rx.pay_valid = pay_valid_q;
  assign rx.pay_last  = pay_last_q;

endmodule

// File: tb/tb_ip_hdr_rx_check.sv
// Self-checking bench for ip_hdr_rx_check: directed datagrams plus random ones,
// each compared against a byte-array reference model of the IPv4 header rules.
module tb_ip_hdr_rx_check;

  localparam logic [31:0] LOCAL_IP = 32'hc0a80002;
`ifdef IP_DST_FILTER_EN
  localparam bit FILTER_ON = 1'b1;
`else
  localparam bit FILTER_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hdr_done, hdr_ok;
  logic [2:0]  err_code;
  logic [3:0]  ver, hdr_len;
  logic [15:0] tot_len, id, offset, rx_check_sum;
  logic [7:0]  ttl, protocol;
  logic [31:0] src_ip, dst_ip;

  ip_hdr_rx_check_if bus ();

  ip_hdr_rx_check #(.LOCAL_IP(LOCAL_IP)) dut (
    .clk(clk), .rst(rst), .rx(bus),
    .hdr_done(hdr_done), .hdr_ok(hdr_ok), .err_code(err_code),
    .ver(ver), .hdr_len(hdr_len), .tot_len(tot_len), .id(id), .offset(offset),
    .rx_check_sum(rx_check_sum), .ttl(ttl), .protocol(protocol),
    .src_ip(src_ip), .dst_ip(dst_ip)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errs   = 0;

  logic [7:0]  fr[$];
  int unsigned acc_cyc[$];
  int unsigned done_cyc[$];
  logic        done_ok[$];
  logic [2:0]  done_err[$];
  logic [7:0]  pay_b[$];
  logic        pay_l[$];
  logic [7:0]  exp_pay[$];
  int          exp_idx, exp_err;
  bit          exp_ok, exp_full, gaps_en;

  // Observe verdict pulses and payload beats away from the active edge.
  always @(negedge clk) begin
    if (hdr_done) begin
      done_cyc.push_back(cyc);
      done_ok.push_back(hdr_ok);
      done_err.push_back(err_code);
    end
    if (bus.pay_valid) begin
      pay_b.push_back(bus.pay_data);
      pay_l.push_back(bus.pay_last);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ocsum(input int hlen);
    int unsigned s = 0;
    for (int i = 0; i < hlen; i += 2) s += {16'd0, fr[i], fr[i+1]};
    while (s > 32'hffff) s = (s & 32'hffff) + (s >> 16);
    return s[15:0];
  endfunction

  task automatic load_hdr(input logic [159:0] h);
    fr.delete();
    for (int k = 19; k >= 0; k--) fr.push_back(h[8*k +: 8]);
  endtask

  task automatic build(input int ihl, input int tl, input int nrest, input logic [31:0] dst);
    logic [15:0] c;
    logic [31:0] r;
    fr.delete();
    fr.push_back(8'h40 | 8'(ihl));
    fr.push_back(8'($urandom));
    fr.push_back(8'(tl >> 8));
    fr.push_back(8'(tl));
    repeat (6) fr.push_back(8'($urandom));
    fr.push_back(8'h00);
    fr.push_back(8'h00);
    r = $urandom;
    for (int k = 3; k >= 0; k--) fr.push_back(r[8*k +: 8]);
    for (int k = 3; k >= 0; k--) fr.push_back(dst[8*k +: 8]);
    repeat (ihl*4 - 20) fr.push_back(8'($urandom));
    c = ~ocsum(ihl*4);
    fr[10] = c[15:8];
    fr[11] = c[7:0];
    repeat (nrest) fr.push_back(8'($urandom));
  endtask

  // Reference: verdict, verdict byte index and forwarded payload for fr.
  task automatic model();
    int n, v, ihl, hlen, tl;
    logic [15:0] s;
    logic [31:0] d;
    n = fr.size();
    v = int'(fr[0][7:4]);
    ihl = int'(fr[0][3:0]);
    hlen = ihl * 4;
    exp_pay.delete();
    exp_full = 1'b0;
    exp_ok = 1'b0;
    if (v != 4) begin exp_err = 1; exp_idx = 0; end
    else if (ihl < 5) begin exp_err = 2; exp_idx = 0; end
    else if (n < hlen) begin exp_err = 4; exp_idx = n - 1; end
    else begin
      exp_full = 1'b1;
      exp_idx = hlen - 1;
      tl = int'({fr[2], fr[3]});
      s = ocsum(hlen);
      d = {fr[16], fr[17], fr[18], fr[19]};
      if (tl < hlen) exp_err = 5;
      else if (s != 16'hffff) exp_err = 3;
      else if (FILTER_ON && d != LOCAL_IP) exp_err = 6;
      else exp_err = 0;
      exp_ok = (exp_err == 0);
      if (exp_ok) for (int i = hlen; i < tl && i < n; i++) exp_pay.push_back(fr[i]);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b0; bus.in_sop = 1'b0; bus.in_eop = 1'b0;
    end
  endtask

  task automatic drive_byte(input logic [7:0] d, input bit sop, input bit eop);
    int g;
    g = gaps_en ? int'($urandom_range(3, 0)) : 0;
    repeat (g) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b0; bus.in_data = 8'($urandom);
      bus.in_sop = 1'($urandom); bus.in_eop = 1'($urandom);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_sop = sop; bus.in_eop = eop;
    acc_cyc.push_back(cyc + 1);
  endtask

  task automatic send(input int n, input bit do_eop, input int rst_at);
    acc_cyc.delete();
    for (int i = 0; i < n; i++) begin
      drive_byte(fr[i], i == 0, do_eop && (i == n - 1));
      rst = (i == rst_at);
    end
    idle(4);
    rst = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int d0, input int p0, input int n_done);
    int np;
    check_eq({tag, "/n_done"}, done_cyc.size() - d0, n_done);
    if (n_done == 1 && done_cyc.size() > d0) begin
      check_eq({tag, "/latency"}, done_cyc[d0], acc_cyc[exp_idx]);
      check_eq({tag, "/ok_pulse"}, done_ok[d0], exp_ok);
      check_eq({tag, "/err_pulse"}, done_err[d0], exp_err);
      check_eq({tag, "/ok_held"}, hdr_ok, exp_ok);
      check_eq({tag, "/err_held"}, err_code, exp_err);
      if (exp_full) begin
        check_eq({tag, "/ver"}, ver, fr[0][7:4]);
        check_eq({tag, "/hdr_len"}, hdr_len, fr[0][3:0]);
        check_eq({tag, "/tot_len"}, tot_len, {fr[2], fr[3]});
        check_eq({tag, "/id"}, id, {fr[4], fr[5]});
        check_eq({tag, "/offset"}, offset, {fr[6], fr[7]});
        check_eq({tag, "/ttl"}, ttl, fr[8]);
        check_eq({tag, "/protocol"}, protocol, fr[9]);
        check_eq({tag, "/csum"}, rx_check_sum, {fr[10], fr[11]});
        check_eq({tag, "/src_ip"}, src_ip, {fr[12], fr[13], fr[14], fr[15]});
        check_eq({tag, "/dst_ip"}, dst_ip, {fr[16], fr[17], fr[18], fr[19]});
      end
    end
    np = pay_b.size() - p0;
    check_eq({tag, "/pay_cnt"}, np, exp_pay.size());
    for (int i = 0; i < np && i < exp_pay.size(); i++) begin
      check_eq($sformatf("%s/pay%0d", tag, i), pay_b[p0+i], exp_pay[i]);
      check_eq($sformatf("%s/last%0d", tag, i), pay_l[p0+i], (i == exp_pay.size() - 1));
    end
  endtask

  task automatic run_frame(input string tag);
    int d0, p0;
    d0 = done_cyc.size();
    p0 = pay_b.size();
    model();
    send(fr.size(), 1'b1, -1);
    check_frame(tag, d0, p0, 1);
  endtask

  initial begin
    int d0, p0, kind, ihl, tl, nrest, cut;
    bus.in_valid = 1'b0; bus.in_data = 8'd0; bus.in_sop = 1'b0; bus.in_eop = 1'b0;
    gaps_en = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst/hdr_done", hdr_done, 1'b0);
    check_eq("rst/hdr_ok", hdr_ok, 1'b0);
    check_eq("rst/err", err_code, 3'd0);
    check_eq("rst/src_ip", src_ip, 32'd0);
    check_eq("rst/tot_len", tot_len, 16'd0);
    check_eq("rst/pay_valid", bus.pay_valid, 1'b0);
    rst = 1'b0;

    load_hdr(160'h4500_0032_0000_0000_4011_F965_c0a80002_c0a80003);
    repeat (36) fr.push_back(8'($urandom));
    p0 = pay_b.size();
    run_frame("valid");
    check_eq("valid/err0", err_code, 3'd0);
    check_eq("valid/src", src_ip, 32'hc0a80002);
    check_eq("valid/n30", pay_b.size() - p0, 30);

    gaps_en = 1'b1;
    run_frame("valid_gaps");
    gaps_en = 1'b0;

    fr[11] = 8'h66;
    run_frame("bad_csum");
    check_eq("bad_csum/err3", err_code, 3'd3);

    load_hdr(160'h4500_0032_0000_0000_4011_F95D_c0a80005_c0a80008);
    repeat (36) fr.push_back(8'($urandom));
    run_frame("dst_other");
    check_eq("dst_other/ok", hdr_ok, !FILTER_ON);

    build(6, 34, 13, LOCAL_IP);
    run_frame("opt4");
    check_eq("opt4/idx23", exp_idx, 23);

    build(5, 30, 10, LOCAL_IP);
    fr[0] = 8'h65;
    run_frame("ver6");
    check_eq("ver6/err1", err_code, 3'd1);

    build(5, 30, 10, LOCAL_IP);
    while (fr.size() > 13) void'(fr.pop_back());
    run_frame("short");
    check_eq("short/err4", err_code, 3'd4);

    // Abort after 8 bytes, then a complete datagram: one verdict, for the second.
    build(5, 40, 20, LOCAL_IP);
    d0 = done_cyc.size();
    p0 = pay_b.size();
    send(8, 1'b0, -1);
    build(5, 28, 10, LOCAL_IP);
    model();
    send(fr.size(), 1'b1, -1);
    check_frame("resop", d0, p0, 1);

    build(5, 30, 10, LOCAL_IP);
    d0 = done_cyc.size();
    p0 = pay_b.size();
    exp_pay.delete();
    send(fr.size(), 1'b1, 15);
    check_frame("rst15", d0, p0, 0);
    check_eq("rst15/hdr_ok", hdr_ok, 1'b0);
    check_eq("rst15/err", err_code, 3'd0);
    check_eq("rst15/ver", ver, 4'd0);
    check_eq("rst15/tot_len", tot_len, 16'd0);
    check_eq("rst15/src_ip", src_ip, 32'd0);

    for (int f = 0; f < 60; f++) begin
      kind = $urandom_range(7, 0);
      ihl = $urandom_range(7, 5);
      gaps_en = 1'($urandom_range(1, 0));
      tl = ihl * 4 + int'($urandom_range(16, 0));
      nrest = $urandom_range(20, 0);
      if (kind == 6) tl = $urandom_range(ihl * 4 - 1, 0);
      build(ihl, tl, nrest, ($urandom_range(1, 0) != 0) ? LOCAL_IP : $urandom);
      case (kind)
        3: fr[11] = fr[11] ^ (8'd1 << $urandom_range(7, 0));
        4: fr[0] = {4'($urandom_range(15, 5)), fr[0][3:0]};
        5: fr[0] = {4'h4, 4'($urandom_range(4, 0))};
        7: begin
          cut = $urandom_range(ihl * 4 - 1, 1);
          while (fr.size() > cut) void'(fr.pop_back());
        end
        default: begin
        end
      endcase
      run_frame($sformatf("rand%0d", f));
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
